// File: rtl/matrix_stream_packer.sv
// matrix_stream_packer
// Deserialises a narrow beat stream into full matrix rows for NUM_MATS
// back-to-back matrices and emits each row as a one-cycle write strobe.
// Optional feature macro: CHECK_EN (per-matrix checksum element + CHK state).
module matrix_stream_packer #(
   parameter int IN_W     = 2,
   parameter int ELEM_W   = 8,
   parameter int ROWS     = 32,
   parameter int COLS     = 32,
   parameter int NUM_MATS = 2
) (
   input  logic                                             eth_refclk,
   input  logic                                             rst,
   input  logic                                             axiiv,
   input  logic [IN_W-1:0]                                  axiid,
   output logic                                             wr_valid,
   output logic [((NUM_MATS > 1) ? $clog2(NUM_MATS) : 1)-1:0] wr_mat,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]         wr_row,
   output logic [COLS*ELEM_W-1:0]                           wr_data,
   output logic                                             busy,
   output logic                                             load_done,
   output logic                                             frame_err,
   output logic                                             chk_err
);

   localparam int BEATS = ELEM_W / IN_W;
   localparam int BW    = (BEATS > 1)    ? $clog2(BEATS)    : 1;
   localparam int EW    = (COLS > 1)     ? $clog2(COLS)     : 1;
   localparam int RW    = (ROWS > 1)     ? $clog2(ROWS)     : 1;
   localparam int MW    = (NUM_MATS > 1) ? $clog2(NUM_MATS) : 1;
   localparam int RDW   = COLS * ELEM_W;

`ifdef CHECK_EN
   typedef enum logic [1:0] {IDLE, LOAD, DONE, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

   state_t            r_state, w_state_nxt;
   logic [BW-1:0]     r_beat;
   logic [EW-1:0]     r_elem_cnt;
   logic [RW-1:0]     r_row;
   logic [MW-1:0]     r_mat;
   logic [ELEM_W-1:0] r_elem;
   logic [RDW-1:0]    r_rowbuf;
   logic [RDW-1:0]    r_wr_data;
   logic              r_wr_valid;
   logic [MW-1:0]     r_wr_mat;
   logic [RW-1:0]     r_wr_row;
   logic              r_load_done;
   logic              r_frame_err;

   logic              w_beat_last, w_elem_last, w_row_last, w_mat_last;
   logic [ELEM_W-1:0] w_elem_shift;
   logic [RDW-1:0]    w_row_shift;
   logic              w_load_beat, w_trunc, w_clear;

`ifdef CHECK_EN
   logic [ELEM_W-1:0] r_sum;
   logic              r_chk_err;
   logic              w_chk_beat, w_chk_bad;
`endif

   // First beat of an element ends up in its MSBs; first element of a row
   // ends up in the row MSBs, so both are plain left shifts.
   assign w_elem_shift = ELEM_W'({r_elem, axiid});
   assign w_row_shift  = RDW'({r_rowbuf, w_elem_shift});
   assign w_beat_last  = (r_beat     == BW'(BEATS - 1));
   assign w_elem_last  = (r_elem_cnt == EW'(COLS - 1));
   assign w_row_last   = (r_row      == RW'(ROWS - 1));
   assign w_mat_last   = (r_mat      == MW'(NUM_MATS - 1));

   // State register
   always_ff @(posedge eth_refclk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and per-cycle control decode
   always_comb begin
      w_state_nxt = r_state;
      w_load_beat = 1'b0;
      w_trunc     = 1'b0;
`ifdef CHECK_EN
      w_chk_beat  = 1'b0;
      w_chk_bad   = 1'b0;
`endif
      case (r_state)
         IDLE, LOAD, DONE: begin
            if (axiiv) begin
               // IDLE/DONE see cleared counters, so a start beat is simply beat 0
               w_load_beat = 1'b1;
               w_state_nxt = LOAD;
               if (w_beat_last && w_elem_last && w_row_last) begin
`ifdef CHECK_EN
                  w_state_nxt = CHK;
`else
                  if (w_mat_last) w_state_nxt = DONE;
`endif
               end
            end else if (r_state == LOAD) begin
               w_trunc     = 1'b1;
               w_state_nxt = IDLE;
            end
         end
`ifdef CHECK_EN
         CHK: begin
            if (axiiv) begin
               w_chk_beat = 1'b1;
               if (w_beat_last) begin
                  if (w_elem_shift == r_sum) begin
                     // matrix counter has already advanced; wrap to 0 means all loaded
                     w_state_nxt = (r_mat == '0) ? DONE : LOAD;
                  end else begin
                     w_chk_bad   = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end
            end else begin
               w_trunc     = 1'b1;
               w_state_nxt = IDLE;
            end
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
`ifdef CHECK_EN
      w_clear = w_trunc | w_chk_bad;
`else
      w_clear = w_trunc;
`endif
   end

   // Counters, element/row assembly and registered outputs
   always_ff @(posedge eth_refclk) begin
      if (rst) begin
         r_beat      <= '0;
         r_elem_cnt  <= '0;
         r_row       <= '0;
         r_mat       <= '0;
         r_elem      <= '0;
         r_rowbuf    <= '0;
         r_wr_data   <= '0;
         r_wr_valid  <= 1'b0;
         r_wr_mat    <= '0;
         r_wr_row    <= '0;
         r_load_done <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef CHECK_EN
         r_sum       <= '0;
         r_chk_err   <= 1'b0;
`endif
      end else begin
         r_wr_valid  <= 1'b0;
         r_wr_data   <= '0;
         r_frame_err <= w_trunc;
         r_load_done <= (w_state_nxt == DONE);
`ifdef CHECK_EN
         r_chk_err   <= w_chk_bad;
`endif
         if (w_clear) begin
            r_beat     <= '0;
            r_elem_cnt <= '0;
            r_row      <= '0;
            r_mat      <= '0;
            r_elem     <= '0;
            r_rowbuf   <= '0;
`ifdef CHECK_EN
            r_sum      <= '0;
`endif
         end else if (w_load_beat) begin
            r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
            r_elem <= w_beat_last ? '0 : w_elem_shift;
            if (w_beat_last) begin
`ifdef CHECK_EN
               r_sum <= r_sum + w_elem_shift;
`endif
               if (w_elem_last) begin
                  r_elem_cnt <= '0;
                  r_rowbuf   <= '0;
                  r_wr_valid <= 1'b1;
                  r_wr_data  <= w_row_shift;
                  r_wr_mat   <= r_mat;
                  r_wr_row   <= r_row;
                  r_row      <= w_row_last ? '0 : r_row + 1'b1;
                  if (w_row_last) r_mat <= w_mat_last ? '0 : r_mat + 1'b1;
               end else begin
                  r_elem_cnt <= r_elem_cnt + 1'b1;
                  r_rowbuf   <= w_row_shift;
               end
            end
         end
`ifdef CHECK_EN
         else if (w_chk_beat) begin
            r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
            r_elem <= w_beat_last ? '0 : w_elem_shift;
            if (w_beat_last) r_sum <= '0;
         end
`endif
      end
   end

   assign wr_valid  = r_wr_valid;
   assign wr_mat    = r_wr_mat;
   assign wr_row    = r_wr_row;
   assign wr_data   = r_wr_data;
   assign load_done = r_load_done;
   assign frame_err = r_frame_err;
`ifdef CHECK_EN
   assign busy      = (r_state == LOAD) || (r_state == CHK);
   assign chk_err   = r_chk_err;
`else
   assign busy      = (r_state == LOAD);
   assign chk_err   = 1'b0;
`endif

endmodule
